// File: rtl/ring_output_arbiter.sv
// Ring router output port: two alternating single-entry VC buffers (even/odd cycle),
// with a per-VC round-robin fill arbiter over the cw / ccw / pe input buffers.
module ring_output_arbiter #(
    parameter int HOP_LSB = 18,
    parameter int HOP_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cw_req,
    input  logic [63:0] cw_data,
    output logic        cw_gnt,
    input  logic        ccw_req,
    input  logic [63:0] ccw_data,
    output logic        ccw_gnt,
    input  logic        pe_req,
    input  logic [63:0] pe_data,
    output logic        pe_gnt,
    output logic [63:0] odo,
    output logic        oso,
    input  logic        oro,
    output logic        polarity
);

    typedef enum logic [1:0] {
        SRC_CW   = 2'd0,
        SRC_CCW  = 2'd1,
        SRC_PE   = 2'd2,
        SRC_NONE = 2'd3
    } src_e;

    logic             polarity_q, polarity_d;
    logic [1:0]       vc_full_q, vc_full_d;
    logic [1:0][63:0] vc_data_q, vc_data_d;
    logic [1:0][1:0]  rr_q, rr_d;
    logic             oso_q, oso_d;
    logic [63:0]      odo_q, odo_d;

    logic        drain_idx;
    logic        fill_idx;
    logic        fill_ok;
    logic [1:0]  rr_cur;
    src_e        winner;
    logic [63:0] win_data;
    logic [63:0] fwd_data;

    always_comb begin
        drain_idx = polarity_q;
        fill_idx  = ~polarity_q;
        // Grants are suppressed while reset is held so nothing is popped upstream.
        fill_ok   = reset && !vc_full_q[fill_idx] && (cw_req || ccw_req || pe_req);
        rr_cur    = rr_q[fill_idx];

        winner = SRC_NONE;
        if (fill_ok) begin
            case (rr_cur)
                2'd1: begin
                    if (ccw_req)     winner = SRC_CCW;
                    else if (pe_req) winner = SRC_PE;
                    else             winner = SRC_CW;
                end
                2'd2: begin
                    if (pe_req)      winner = SRC_PE;
                    else if (cw_req) winner = SRC_CW;
                    else             winner = SRC_CCW;
                end
                default: begin
                    if (cw_req)       winner = SRC_CW;
                    else if (ccw_req) winner = SRC_CCW;
                    else              winner = SRC_PE;
                end
            endcase
        end

        cw_gnt  = (winner == SRC_CW);
        ccw_gnt = (winner == SRC_CCW);
        pe_gnt  = (winner == SRC_PE);

        case (winner)
            SRC_CW:  win_data = cw_data;
            SRC_CCW: win_data = ccw_data;
            SRC_PE:  win_data = pe_data;
            default: win_data = '0;
        endcase

        // One hop consumed on this link: hop field is halved.
        fwd_data = win_data;
        fwd_data[HOP_LSB +: HOP_W] = {1'b0, win_data[HOP_LSB+1 +: HOP_W-1]};

        polarity_d = ~polarity_q;
        vc_full_d  = vc_full_q;
        vc_data_d  = vc_data_q;
        rr_d       = rr_q;
        oso_d      = 1'b0;
        odo_d      = '0;

        if (vc_full_q[drain_idx] && oro) begin
            oso_d                = 1'b1;
            odo_d                = vc_data_q[drain_idx];
            vc_full_d[drain_idx] = 1'b0;
        end

        if (winner != SRC_NONE) begin
            vc_full_d[fill_idx] = 1'b1;
            vc_data_d[fill_idx] = fwd_data;
            rr_d[fill_idx]      = (winner == SRC_PE) ? 2'd0 : 2'(winner + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            polarity_q <= 1'b0;
            vc_full_q  <= '0;
            vc_data_q  <= '0;
            rr_q       <= '0;
            oso_q      <= 1'b0;
            odo_q      <= '0;
        end else begin
            polarity_q <= polarity_d;
            vc_full_q  <= vc_full_d;
            vc_data_q  <= vc_data_d;
            rr_q       <= rr_d;
            oso_q      <= oso_d;
            odo_q      <= odo_d;
        end
    end

    assign odo      = odo_q;
    assign oso      = oso_q;
    assign polarity = polarity_q;

endmodule

// File: tb/tb_ring_output_arbiter.sv
// Directed and randomized checks of ring_output_arbiter against a queue-free
// behavioural model of the two VC buffers and their round-robin pointers.
module tb_ring_output_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cw_req = 1'b0, ccw_req = 1'b0, pe_req = 1'b0;
    logic [63:0] cw_data = '0, ccw_data = '0, pe_data = '0;
    logic        cw_gnt, ccw_gnt, pe_gnt;
    logic [63:0] odo;
    logic        oso;
    logic        oro = 1'b0;
    logic        polarity;

    ring_output_arbiter #(.HOP_LSB(18), .HOP_W(8)) dut (
        .clk(clk), .reset(reset),
        .cw_req(cw_req), .cw_data(cw_data), .cw_gnt(cw_gnt),
        .ccw_req(ccw_req), .ccw_data(ccw_data), .ccw_gnt(ccw_gnt),
        .pe_req(pe_req), .pe_data(pe_data), .pe_gnt(pe_gnt),
        .odo(odo), .oso(oso), .oro(oro), .polarity(polarity)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit          m_pol;
    bit          m_full [2];
    logic [63:0] m_data [2];
    int          m_rr   [2];
    bit          m_oso;
    logic [63:0] m_odo;
    logic [2:0]  obs_gnt;   // {pe, ccw, cw} as seen before the last edge

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hop_fwd(input logic [63:0] d);
        logic [63:0] mask;
        logic [63:0] hop;
        mask = 64'hFF << 18;
        hop  = (d >> 18) & 64'hFF;
        return (d & ~mask) | ((hop / 2) << 18);
    endfunction

    function automatic logic [63:0] src_data(input int s);
        case (s)
            0: return cw_data;
            1: return ccw_data;
            default: return pe_data;
        endcase
    endfunction

    // req bits: [0]=cw [1]=ccw [2]=pe
    task automatic step(input logic r, input logic [2:0] req, input logic o);
        int w;
        int start;
        int f;
        int d;
        reset = r; cw_req = req[0]; ccw_req = req[1]; pe_req = req[2]; oro = o;
        #1;
        w = -1;
        f = m_pol ? 0 : 1;
        d = m_pol ? 1 : 0;
        if (r && !m_full[f] && req != 3'b000) begin
            start = (m_rr[f] == 3) ? 0 : m_rr[f];
            for (int k = 2; k >= 0; k--)
                if (req[(start + k) % 3]) w = (start + k) % 3;
        end
        obs_gnt = {pe_gnt, ccw_gnt, cw_gnt};
        chk("cw_gnt",  cw_gnt,  (w == 0));
        chk("ccw_gnt", ccw_gnt, (w == 1));
        chk("pe_gnt",  pe_gnt,  (w == 2));
        @(posedge clk);
        if (!r) begin
            m_pol = 0; m_full[0] = 0; m_full[1] = 0; m_data[0] = '0; m_data[1] = '0;
            m_rr[0] = 0; m_rr[1] = 0; m_oso = 0; m_odo = '0;
        end else begin
            if (m_full[d] && o) begin
                m_oso = 1; m_odo = m_data[d]; m_full[d] = 0;
            end else begin
                m_oso = 0; m_odo = '0;
            end
            if (w >= 0) begin
                m_data[f] = hop_fwd(src_data(w));
                m_full[f] = 1;
                m_rr[f]   = (w + 1) % 3;
            end
            m_pol = !m_pol;
        end
        #1;
        chk("oso", oso, m_oso);
        chk("odo", odo, m_odo);
        chk("polarity", polarity, m_pol);
    endtask

    task automatic rnd_data();
        cw_data  = {$urandom, $urandom};
        ccw_data = {$urandom, $urandom};
        pe_data  = {$urandom, $urandom};
    endtask

    logic [2:0]  rr_exp [7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    logic [63:0] saved;
    logic [63:0] hop_mask;

    initial begin
        hop_mask = 64'hFF << 18;

        // reset and basic flow
        rnd_data();
        step(0, 3'($urandom_range(0, 7)), 1);
        step(0, 3'($urandom_range(0, 7)), 1);
        chk("rst_polarity", polarity, 1'b0);
        chk("rst_oso", oso, 1'b0);
        pe_data = 64'h0000_0000_0080_0000;
        step(1, 3'b100, 1);
        chk("basic_pe_gnt", obs_gnt, 3'b100);
        step(1, 3'b000, 1);
        chk("basic_oso", oso, 1'b1);
        chk("basic_odo", odo, 64'h0000_0000_0040_0000);

        // round robin with all requesters held
        for (int i = 0; i < 7; i++) begin
            rnd_data();
            step(1, 3'b111, 1);
            chk("rr_seq", obs_gnt, rr_exp[i]);
        end

        // backpressure
        for (int i = 0; i < 5; i++) begin
            rnd_data();
            step(1, 3'b111, 0);
            if (i >= 1) begin
                chk("bp_no_gnt", obs_gnt, 3'b000);
                chk("bp_no_oso", oso, 1'b0);
            end
        end
        rnd_data();
        step(1, 3'b111, 1);
        chk("bp_release_oso", oso, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rnd_data();
            step(1, 3'b111, 1);
        end

        // reset mid-operation with both VCs full
        for (int i = 0; i < 3; i++) begin
            rnd_data();
            step(1, 3'b111, 0);
        end
        step(0, 3'b111, 0);
        chk("midrst_gnt", obs_gnt, 3'b000);
        chk("midrst_oso", oso, 1'b0);
        chk("midrst_pol", polarity, 1'b0);
        step(1, 3'b000, 1);
        chk("midrst_after0", oso, 1'b0);
        step(1, 3'b000, 1);
        chk("midrst_after1", oso, 1'b0);

        // hop field edges
        step(0, 3'b000, 0);
        cw_data = {$urandom, $urandom};
        cw_data[25:18] = 8'h01;
        saved = cw_data;
        step(1, 3'b001, 1);
        step(1, 3'b000, 1);
        chk("hop01", odo, saved & ~hop_mask);
        cw_data = {$urandom, $urandom};
        cw_data[25:18] = 8'hFF;
        saved = cw_data;
        step(1, 3'b001, 1);
        step(1, 3'b000, 1);
        chk("hopFF", odo, (saved & ~hop_mask) | (64'h7F << 18));

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rnd_data();
            step(($urandom_range(0, 39) != 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
